// File: rtl/bpm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpm_pkg
// Description : Shared constants, reporter state encoding and the
//               double-dabble step used by the BPM UART reporter.
// Revision    : 1.0 - initial release
// ============================================================================
package bpm_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_STOP    = 3'd4
    } rpt_state_t;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
    // the next binary bit in at the bottom.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd,
                                                input logic        in_bit);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[10:0], in_bit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer. A start request is accepted while the
//               line is idle or during the final cycle of a stop bit, so
//               characters can be chained with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = bpm_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int              c_TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0] c_BIT_LAST = c_TW'(CLKS_PER_BIT - 1);

    logic            r_active;
    logic [c_TW-1:0] r_timer;
    logic [3:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_done;
    logic            w_bit_end;
    logic            w_stop_end;

    // Bit boundary decode; w_stop_end marks the last cycle of the stop bit.
    always_comb begin
        w_bit_end  = (r_timer == c_BIT_LAST);
        w_stop_end = r_active && w_bit_end && (r_bit_idx == 4'd9);
    end

    assign ready = !r_active || w_stop_end;
    assign tx    = r_tx;
    assign done  = r_done;

    // Bit sequencing: index 0 is the start bit, 1..8 data LSB first, 9 stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_timer   <= '0;
            r_bit_idx <= 4'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && ready) begin
                r_active  <= 1'b1;
                r_timer   <= '0;
                r_bit_idx <= 4'd0;
                r_shift   <= data;
                r_tx      <= 1'b0;
            end else if (r_active) begin
                if (w_bit_end) begin
                    r_timer <= '0;
                    if (r_bit_idx == 4'd9) begin
                        r_active  <= 1'b0;
                        r_bit_idx <= 4'd0;
                        r_tx      <= 1'b1;
                    end else begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == 4'd8) begin
                            // Payload finished; the stop bit begins now.
                            r_tx   <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpm_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module      : bpm_uart_reporter
// Description : Accepts a BPM result over the valid/copied handshake,
//               converts it to three ASCII decimal digits and sends them
//               (optionally followed by CR LF) as UART 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
module bpm_uart_reporter #(
    parameter int CLKS_PER_BIT = bpm_pkg::DEFAULT_CLKS_PER_BIT,
    parameter int SEND_CRLF    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] bpm_value,
    input  logic       bpm_valid,
    output logic       bpm_copied,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done
);

    import bpm_pkg::*;

    localparam int         c_NUM_CHARS = (SEND_CRLF != 0) ? 5 : 3;
    localparam logic [2:0] c_LAST_CHAR = 3'(c_NUM_CHARS - 1);

    rpt_state_t  r_state;
    logic [7:0]  r_shadow;
    logic [11:0] r_bcd;
    logic [2:0]  r_conv_cnt;
    logic [2:0]  r_char_idx;
    logic        r_bpm_copied;
    logic        r_busy;
    logic        r_frame_done;

    logic        w_start;
    logic        w_ready;
    logic        w_done;
    logic        w_tx;
    logic [2:0]  w_send_idx;
    logic [7:0]  w_char;

    // Character selection; in STOP the next character is presented so it can
    // be chained onto the final cycle of the current stop bit.
    always_comb begin
        w_send_idx = r_char_idx;
        if (r_state == ST_STOP) begin
            w_send_idx = r_char_idx + 3'd1;
        end
        w_start = (r_state == ST_START) ||
                  ((r_state == ST_STOP) && w_ready && (r_char_idx != c_LAST_CHAR));
        case (w_send_idx)
            3'd0:    w_char = ASCII_ZERO + {4'd0, r_bcd[11:8]};
            3'd1:    w_char = ASCII_ZERO + {4'd0, r_bcd[7:4]};
            3'd2:    w_char = ASCII_ZERO + {4'd0, r_bcd[3:0]};
            3'd3:    w_char = ASCII_CR;
            default: w_char = ASCII_LF;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .data  (w_char),
        .tx    (w_tx),
        .ready (w_ready),
        .done  (w_done)
    );

    // Handshake, conversion and character sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shadow     <= 8'd0;
            r_bcd        <= 12'd0;
            r_conv_cnt   <= 3'd0;
            r_char_idx   <= 3'd0;
            r_bpm_copied <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_bpm_copied <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en && bpm_valid) begin
                        r_shadow     <= bpm_value;
                        r_bcd        <= 12'd0;
                        r_conv_cnt   <= 3'd0;
                        r_char_idx   <= 3'd0;
                        r_bpm_copied <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    // The shadow doubles as the shift source; only its BCD
                    // image is needed once conversion starts.
                    r_bcd      <= dabble_step(r_bcd, r_shadow[7]);
                    r_shadow   <= {r_shadow[6:0], 1'b0};
                    r_conv_cnt <= r_conv_cnt + 3'd1;
                    if (r_conv_cnt == 3'd7) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Serializer is idle here, so the first character is
                    // accepted on this edge.
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_ready) begin
                        if (r_char_idx == c_LAST_CHAR) begin
                            r_char_idx   <= 3'd0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            // Next start bit was launched on this edge.
                            r_char_idx <= r_char_idx + 3'd1;
                            r_state    <= ST_DATA;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bpm_copied = r_bpm_copied;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign uart_tx    = w_tx;

endmodule
`default_nettype wire
